// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer between the datapath
// and a word-addressed data memory. It captures one request, strobes the memory
// for exactly one cycle, waits for mem_ack with a 15-cycle timeout, and writes
// load data back to the register file.
// Optional feature: define LSU_BYTE_ACCESS_EN to honour req_byte (LDRB/STRB).
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_rd,
    input  logic        req_byte,
    output logic [10:0] mem_addr,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  w_addr_ldr,
    output logic        w_en_ldr,
    output logic [31:0] w_data_ldr,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  tmo_cnt;
    logic        is_load_q;
    logic        accept;
    logic        eff_byte;
    logic        misaligned;
    logic        in_mem_phase;
    logic        timeout;
    logic [31:0] load_data;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;

    // Only the word address bits reach the memory; the rest of the byte address is dropped.
    logic [18:0] addr_hi_unused;
    assign addr_hi_unused = req_addr[31:13];

`ifdef LSU_BYTE_ACCESS_EN
    logic       byte_q;
    logic [1:0] lane_q;
    logic [7:0] lane_byte;

    assign eff_byte    = req_byte;
    assign store_be    = eff_byte ? (4'b0001 << req_addr[1:0]) : 4'hF;
    assign store_wdata = eff_byte ? {4{req_wdata[7:0]}} : req_wdata;

    // Pick the addressed byte lane out of the returned word
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        lane_byte = mem_rdata[7:0];
        case (lane_q)
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            2'd3:    lane_byte = mem_rdata[31:24];
            default: lane_byte = mem_rdata[7:0];
        endcase
    end

    assign load_data = byte_q ? {24'h0, lane_byte} : mem_rdata;

    // Remember byte mode and lane of the accepted request for load data extraction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q <= 1'b0;
            lane_q <= 2'd0;
        end else if (accept) begin
            byte_q <= req_byte;
            lane_q <= req_addr[1:0];
        end
    end
`else
    // Without byte support every access is a word access and req_byte is ignored.
    logic byte_unused;
    assign byte_unused = req_byte;
    assign eff_byte    = 1'b0;
    assign store_be    = 4'hF;
    assign store_wdata = req_wdata;
    assign load_data   = mem_rdata;
`endif

    assign accept       = req_valid && (state == IDLE);
    assign misaligned   = !eff_byte && (req_addr[1:0] != 2'b00);
    assign in_mem_phase = (state == ISSUE) || (state == WAIT);
    // The 15th consecutive cycle without ack ends the transaction.
    assign timeout      = in_mem_phase && !mem_ack && (tmo_cnt == 4'd14);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and per-state strobes
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        w_en_ldr  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid && !misaligned) state_nx = ISSUE;
            end
            ISSUE: begin
                mem_rd_en = is_load_q;
                mem_wr_en = !is_load_q;
                if (mem_ack)      state_nx = is_load_q ? WB : IDLE;
                else if (timeout) state_nx = IDLE;
                else              state_nx = WAIT;
            end
            WAIT: begin
                if (mem_ack)      state_nx = is_load_q ? WB : IDLE;
                else if (timeout) state_nx = IDLE;
            end
            WB: begin
                w_en_ldr = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Ack timeout counter: restarts on each accepted request, counts ack-less memory cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          tmo_cnt <= 4'd0;
        else if (accept)                  tmo_cnt <= 4'd0;
        else if (in_mem_phase && !mem_ack) tmo_cnt <= tmo_cnt + 4'd1;
    end

    // Capture request fields; memory-side outputs stay stable until the next acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_load_q  <= 1'b0;
            mem_addr   <= 11'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
            w_addr_ldr <= 4'd0;
        end else if (accept) begin
            is_load_q  <= req_is_load;
            mem_addr   <= req_addr[12:2];
            mem_wdata  <= store_wdata;
            mem_be     <= store_be;
            w_addr_ldr <= req_rd;
        end
    end

    // Latch load data on the acknowledging cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     w_data_ldr <= 32'd0;
        else if (in_mem_phase && mem_ack && is_load_q) w_data_ldr <= load_data;
    end

    // One-cycle error pulse after a misaligned request or a memory timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= (accept && misaligned) || timeout;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 req_valid  input  1  datapath requests a memory access.
REQ-004 req_ready  output  1  high only in IDLE; request accepted on an edge with req_valid & req_ready.
REQ-005 req_is_load  input  1  1 = LDR, 0 = STR.
REQ-006 req_addr  input  32  byte address (datapath_out).
REQ-007 req_wdata  input  32  store data (str_data).
REQ-008 req_rd  input  4  load destination register.
REQ-009 req_byte  input  1  byte access (LDRB/STRB); used only when LSU_BYTE_ACCESS_EN is defined.
REQ-010 mem_addr  output  11  word address = captured addr[12:2].
REQ-011 mem_rd_en / mem_wr_en  output  1 each  read/write strobe to data memory.
REQ-012 mem_wdata  output  32  write data; mem_be  output  4  byte enables.
REQ-013 mem_rdata  input  32  read data, valid with mem_ack.
REQ-014 mem_ack  input  1  memory completion, read or write.
REQ-015 w_addr_ldr  output  4, w_en_ldr  output  1, w_data_ldr  output  32  load writeback port to regfile.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err  output  1  one-cycle pulse on misalignment or timeout.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, WB.
REQ-019 On acceptance, addr, wdata, rd, is_load and byte SHALL be captured; FSM -> ISSUE, except a misaligned word access (addr[1:0] != 0, non-byte), which SHALL pulse err next cycle and stay in IDLE with no memory strobe.
REQ-020 ISSUE: mem_rd_en (load) or mem_wr_en (store) high exactly one cycle; mem_addr/mem_wdata/mem_be held stable from ISSUE through end of transaction.
REQ-021 mem_ack SHALL be sampled in ISSUE and WAIT; ISSUE without ack -> WAIT; WAIT holds until ack.
REQ-022 Load ack: mem_rdata (lane-processed) captured into w_data_ldr; FSM -> WB. Store ack: FSM -> IDLE.
REQ-023 WB: w_en_ldr high exactly one cycle with w_addr_ldr = captured rd; then IDLE; rd = 15 receives no special treatment.
REQ-024 Minimum load latency: accept edge T, mem_rd_en in cycle T+1, w_en_ldr in cycle T+2; minimum store: req_ready again in cycle T+2.
REQ-025 Timeout counter (4-bit) cleared on entering ISSUE, incremented each ISSUE/WAIT cycle without ack; at 15 cycles without ack: err pulse, FSM -> IDLE, no writeback.
REQ-026 mem_ack received in IDLE or WB SHALL be ignored.
REQ-027 Word access: mem_be = 4'hF, mem_wdata = wdata, load data = mem_rdata.
REQ-028 Outputs w_en_ldr, mem_rd_en, mem_wr_en, err SHALL be 0 whenever not required above.

Reset
REQ-029 rst SHALL immediately force IDLE, clear counter and all captured state; all outputs 0 except req_ready = 1.
REQ-030 rst during any state SHALL abandon the transaction with no writeback and no err.

Configuration
REQ-031 Macro LSU_BYTE_ACCESS_EN defined: req_byte honoured; byte store mem_wdata = {4{wdata[7:0]}}, mem_be = 1 << addr[1:0]; byte load data = zero-extended mem_rdata byte at lane addr[1:0]; byte accesses never misaligned.
REQ-032 Macro undefined: req_byte ignored, every access is a word access per REQ-027 and REQ-019.

Verification
REQ-033 Load addr 0x0000_0010, rd=3, ack in ISSUE, rdata 0xDEAD_BEEF -> mem_addr=4, w_en_ldr cycle T+2, w_addr_ldr=3, w_data_ldr=0xDEAD_BEEF.
REQ-034 Store addr 0x20, wdata 0x1234_5678, ack after 3 WAIT cycles -> mem_wr_en one pulse, mem_addr=8, mem_be=F, no w_en_ldr, req_ready after ack.
REQ-035 Load with no ack -> err pulse after 15 cycles, IDLE, no w_en_ldr; late ack then ignored.
REQ-036 Word load addr 0x22 -> err pulse next cycle, no mem_rd_en, req_ready stays 1.
REQ-037 LSU_BYTE_ACCESS_EN: LDRB addr 0x23, rdata 0xAABB_CCDD -> w_data_ldr=0x0000_00AA; STRB addr 0x21, wdata 0x55 -> mem_be=4'b0010, mem_wdata=0x5555_5555.
REQ-038 rst asserted in WAIT -> IDLE at once, subsequent ack produces no writeback, outputs per REQ-029.
